// File: rtl/bram_rd_arbiter_if.sv
// Read-port bundle between the loaders, the arbiter and BRAM port B.
// The slave modport is the arbiter's view. The master modport is the
// loader/BRAM side.
interface bram_rd_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ-1:0]        last_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      bram_enb_o;
  logic [ADDR_W-1:0]         bram_addrb_o;
  logic [DATA_W-1:0]         bram_dout_i;
  logic [DATA_W-1:0]         rdata_o;
  logic [NUM_REQ-1:0]        rvalid_o;
  logic                      busy_o;

  modport slave (
    input  req_i, addr_i, last_i, bram_dout_i,
    output gnt_o, bram_enb_o, bram_addrb_o, rdata_o, rvalid_o, busy_o
  );

  modport master (
    output req_i, addr_i, last_i, bram_dout_i,
    input  gnt_o, bram_enb_o, bram_addrb_o, rdata_o, rvalid_o, busy_o
  );
endinterface

// File: rtl/bram_rd_arbiter.sv
// bram_rd_arbiter: shares BRAM read port B between NUM_REQ burst loaders.
// Round-robin between bursts. A granted burst keeps the port until its last beat.
// Read data is returned RD_LATENCY cycles after acceptance, tagged by a one-hot rvalid.
// Optional build macro BRAM_ARB_STATS_EN adds per-requester beat counters and
// longest-wait statistics.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no burst owns the port; round-robin grant from rr_ptr
//  LOCK  | owner_q is mid-burst; grant pinned to owner until last beat
module bram_rd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_rd_arbiter_if.slave      bus
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] stat_beats_o,
  output logic [NUM_REQ*16-1:0] stat_wait_max_o
`endif
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] tag_q [RD_LATENCY];

  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] gnt_vec;
  logic               accept;
  logic               accept_last;
  logic               tag_any;

  // Grant selection: pinned owner while locked, else first request from rr_ptr upward.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    cand_idx  = '0;
    if (state_q == LOCK) begin
      gnt_found = 1'b1;
      gnt_idx   = owner_q;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
        if (!gnt_found && bus.req_i[cand_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
    end
  end

  assign gnt_vec     = gnt_found ? (ONE_HOT0 << gnt_idx) : '0;
  assign accept      = |(bus.req_i & gnt_vec);
  assign accept_last = accept & bus.last_i[gnt_idx];
  assign next_ptr    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // Next-state logic: lock on a non-last beat, release and advance rr_ptr on the last beat.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.last_i[gnt_idx]) begin
            rr_ptr_d = next_ptr;
          end else begin
            state_d = LOCK;
            owner_d = gnt_idx;
          end
        end
      end
      LOCK: begin
        if (accept_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and burst owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Owner-tag shift register that matches the fixed BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= accept ? gnt_vec : '0;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Any read still in flight keeps the arbiter busy.
  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) tag_any = tag_any | (|tag_q[i]);
  end

  assign bus.gnt_o        = gnt_vec;
  assign bus.bram_enb_o   = accept;
  assign bus.bram_addrb_o = bus.addr_i[ADDR_W*int'(gnt_idx) +: ADDR_W];
  assign bus.rdata_o      = bus.bram_dout_i;
  assign bus.rvalid_o     = tag_q[RD_LATENCY-1];
  assign bus.busy_o       = (state_q == LOCK) | tag_any;

`ifdef BRAM_ARB_STATS_EN
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
    logic [31:0] beats_q;
    logic [15:0] run_q, run_d, max_q;

    // Length of the current stall run for requester k, saturating.
    always_comb begin
      run_d = 16'd0;
      if (bus.req_i[k] && !gnt_vec[k]) run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
    end

    // Saturating beat counter and running maximum of the stall run.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        beats_q <= '0;
        run_q   <= '0;
        max_q   <= '0;
      end else begin
        if (bus.req_i[k] && gnt_vec[k] && beats_q != 32'hFFFF_FFFF) beats_q <= beats_q + 32'd1;
        run_q <= run_d;
        if (run_d > max_q) max_q <= run_d;
      end
    end

    assign stat_beats_o[k*32 +: 32]    = beats_q;
    assign stat_wait_max_o[k*16 +: 16] = max_q;
  end
`endif
endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed bench for bram_rd_arbiter with a 2-cycle BRAM read model.
module tb_bram_rd_arbiter;
  localparam int NUM_REQ = 2, ADDR_W = 12, DATA_W = 16, RD_LATENCY = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bram_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef BRAM_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] stat_beats;
  logic [NUM_REQ*16-1:0] stat_wait_max;
`endif

  bram_rd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRAM_ARB_STATS_EN
    ,
    .stat_beats_o    (stat_beats),
    .stat_wait_max_o (stat_wait_max)
`endif
  );

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return {4'hD, a};
  endfunction

  // BRAM model: the address is registered, then the output is registered (two cycles).
  logic [DATA_W-1:0] mem_p1;
  always @(posedge clk) begin
    if (bus.bram_enb_o) mem_p1 <= data_of(bus.bram_addrb_o);
    bus.bram_dout_i <= mem_p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_i = '0;
    bus.last_i = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_i = '0; bus.last_i = '0; bus.addr_i = '0;
    #2;
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt_o); end
    checks++; if (bus.bram_enb_o !== 1'b0) begin errors++; $display("FAIL reset_enb got=%b exp=0", bus.bram_enb_o); end
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", bus.rvalid_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    bus.req_i = 2'b10;
    #1;
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL reset_gnt_req got=%b exp=10", bus.gnt_o); end
    bus.req_i = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.addr_i = {12'h0AB, 12'h010};
    bus.req_i = 2'b01; bus.last_i = 2'b01;
    #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", bus.gnt_o); end
    checks++; if (bus.bram_addrb_o !== 12'h010) begin errors++; $display("FAIL single_addr got=%h exp=010", bus.bram_addrb_o); end
    checks++; if (bus.bram_enb_o !== 1'b1) begin errors++; $display("FAIL single_enb got=%b exp=1", bus.bram_enb_o); end
    tick();
    bus.req_i = '0;
    #1;
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL single_rvalid_early got=%b exp=00", bus.rvalid_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus.busy_o); end
    tick();
    checks++; if (bus.rvalid_o !== 2'b01) begin errors++; $display("FAIL single_rvalid got=%b exp=01", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 16'hD010) begin errors++; $display("FAIL single_rdata got=%h exp=d010", bus.rdata_o); end
    tick();
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL single_rvalid_late got=%b exp=00", bus.rvalid_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g, exp_rv;
    do_reset();
    bus.addr_i = {12'h200, 12'h100};
    bus.last_i = 2'b11;
    for (int c = 0; c < 9; c++) begin
      bus.req_i = (c < 6) ? 2'b11 : 2'b00;
      #1;
      exp_g = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (bus.gnt_o !== exp_g) begin errors++; $display("FAIL alt_gnt c=%0d got=%b exp=%b", c, bus.gnt_o, exp_g); end
      checks++; if (bus.bram_enb_o !== (c < 6)) begin errors++; $display("FAIL alt_enb c=%0d got=%b", c, bus.bram_enb_o); end
      if (c >= 2) begin
        exp_rv = (c - 2 >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
        checks++; if (bus.rvalid_o !== exp_rv) begin errors++; $display("FAIL alt_rvalid c=%0d got=%b exp=%b", c, bus.rvalid_o, exp_rv); end
        if (exp_rv != 2'b00) begin
          checks++;
          if (bus.rdata_o !== ((exp_rv == 2'b01) ? 16'hD100 : 16'hD200)) begin
            errors++; $display("FAIL alt_rdata c=%0d got=%h", c, bus.rdata_o);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_burst();
    logic [1:0] exp_g;
    do_reset();
    bus.addr_i = {12'h300, 12'h040};
    for (int c = 0; c < 6; c++) begin
      bus.req_i  = (c < 5) ? 2'b11 : 2'b00;
      bus.last_i = (c >= 3) ? 2'b11 : 2'b10;
      #1;
      exp_g = (c < 4) ? 2'b01 : ((c == 4) ? 2'b10 : 2'b00);
      checks++; if (bus.gnt_o !== exp_g) begin errors++; $display("FAIL burst_gnt c=%0d got=%b exp=%b", c, bus.gnt_o, exp_g); end
      if (c >= 1 && c <= 3) begin
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL burst_busy c=%0d got=%b exp=1", c, bus.busy_o); end
      end
      if (c == 4) begin
        checks++; if (bus.bram_addrb_o !== 12'h300) begin errors++; $display("FAIL burst_addr got=%h exp=300", bus.bram_addrb_o); end
      end
      tick();
    end
    tick(); tick();
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL burst_drain got=%b exp=0", bus.busy_o); end
`ifdef BRAM_ARB_STATS_EN
    checks++; if (stat_beats[31:0] !== 32'd4) begin errors++; $display("FAIL stat_beats0 got=%0d exp=4", stat_beats[31:0]); end
    checks++; if (stat_wait_max[31:16] !== 16'd4) begin errors++; $display("FAIL stat_wait1 got=%0d exp=4", stat_wait_max[31:16]); end
`endif
  endtask

  task automatic test_bubble();
    do_reset();
    bus.addr_i = {12'h111, 12'h022};
    for (int c = 0; c < 7; c++) begin
      bus.req_i  = (c == 0 || c == 4) ? 2'b11 : ((c == 6) ? 2'b00 : 2'b10);
      bus.last_i = (c >= 4) ? 2'b11 : 2'b10;
      #1;
      if (c <= 4) begin
        checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL bubble_gnt c=%0d got=%b exp=01", c, bus.gnt_o); end
        checks++; if (bus.bram_enb_o !== (c == 0 || c == 4)) begin errors++; $display("FAIL bubble_enb c=%0d got=%b", c, bus.bram_enb_o); end
      end
      if (c >= 1 && c <= 3) begin
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL bubble_lock c=%0d got=%b exp=1", c, bus.busy_o); end
      end
      if (c == 4) begin
        checks++; if (bus.bram_addrb_o !== 12'h022) begin errors++; $display("FAIL bubble_addr got=%h exp=022", bus.bram_addrb_o); end
      end
      if (c == 5) begin
        checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL bubble_next got=%b exp=10", bus.gnt_o); end
        checks++; if (bus.bram_addrb_o !== 12'h111) begin errors++; $display("FAIL bubble_addr1 got=%h exp=111", bus.bram_addrb_o); end
      end
      tick();
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.addr_i = {12'h000, 12'h005};
    bus.req_i = 2'b01; bus.last_i = 2'b11;
    #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL rmid_gnt got=%b exp=01", bus.gnt_o); end
    tick();
    bus.req_i = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL rmid_rvalid_rst got=%b exp=00", bus.rvalid_o); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL rmid_rvalid c=%0d got=%b exp=00", c, bus.rvalid_o); end
      tick();
    end
    bus.req_i = 2'b11;
    #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL rmid_ptr got=%b exp=01", bus.gnt_o); end
    tick();
    bus.req_i = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_burst();
    test_bubble();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
